conv_sysarr_mul_share_arb: RTL and testbench
============================================

Name: conv_sysarr_mul_share_arb

Overview:
- Shares one pipelined unsigned multiplier (6-bit x 18-bit -> 24-bit, clock-enable gated) between N_REQ systolic-array requesters.
- Round-robin arbiter issues at most one operand pair per cycle.
- A tag shift-register tracks requester ID in lockstep with the multiplier pipeline and returns each product with its ID.
- Backpressure on the response port freezes the whole pipeline through the multiplier's ce, so no result is ever dropped.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; equals ceil(log2(N_REQ)).
- MUL_LAT, 3, number of ce-enabled clock edges from operands presented on mul_din0/mul_din1 to product on mul_dout.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_a  in  6*N_REQ  packed a operands; requester i at bits [6i+5:6i].
- req_b  in  18*N_REQ  packed b operands; requester i at bits [18i+17:18i].
- req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- mul_ce  out  1  clock enable to multiplier.
- mul_din0  out  6  multiplier a operand.
- mul_din1  out  18  multiplier b operand.
- mul_dout  in  24  multiplier product.
- rsp_valid  out  1  product valid.
- rsp_id  out  ID_W  requester index of product.
- rsp_data  out  24  product; equals mul_dout.
- rsp_ready  in  1  downstream accepts product.
- idle  out  1  no request in flight.
- cnt_issue  out  CNT_W  accepted requests since reset.
- cnt_stall  out  CNT_W  cycles with mul_ce low.

Behaviour:
- Stall and enable:
  - stall = rsp_valid & ~rsp_ready.
  - mul_ce = ~stall, forced 0 while reset low.
- Arbitration (combinational):
  - Scan requesters from rr_ptr upward, modulo N_REQ.
  - The first i with req_valid[i] is granted; req_ready[i] = grant[i] & mul_ce.
  - mul_din0/mul_din1 = granted operands, else 0.
- Pointer update: on accept, rr_ptr <= (granted index + 1) mod N_REQ; otherwise rr_ptr holds.
- Tag pipeline:
  - MUL_LAT stages, each holding {valid, id}; shifts only on edges with mul_ce = 1.
  - Stage 0 loads {accept, granted id}.
  - Non-accept cycles with mul_ce = 1 insert bubbles (valid = 0).
- Response:
  - rsp_valid = last stage valid; rsp_id = last stage id; rsp_data = mul_dout.
  - Latency: an accept at edge t yields rsp_valid in the cycle after the MUL_LAT-th ce-enabled edge, counting edge t; 3 cycles with no stalls.
- Stall behaviour:
  - Tags, multiplier registers, rsp_* and rr_ptr hold.
  - req_ready is all-zero.
  - Products are never lost or duplicated; rsp_* stay stable until rsp_ready.
- Throughput: 1 result/cycle while rsp_ready = 1 and requests are present.
- idle = 1 when all tag valids are 0 (bubbles in the multiplier are ignored).
- Counters:
  - cnt_issue increments on each accept.
  - cnt_stall increments each cycle mul_ce = 0 outside reset.
  - Both wrap at 2^CNT_W with no saturation.
- Boundaries:
  - req_valid deasserted in the same cycle as a grant: no accept, pointer unchanged.
  - Single requester continuously valid: granted every non-stall cycle.
  - Stall and new request in the same cycle: request waits, no accept.
  - rr_ptr wraps N_REQ-1 -> 0.
- Reset values (asynchronous, any time including mid-operation):
  - All tag valids 0, rr_ptr 0, counters 0.
  - rsp_valid 0, idle 1, req_ready 0.
  - In-flight products are discarded; multiplier contents are don't-care because their tags are cleared.

Test Plan:
- Single op: reset release; req0 a=5, b=1000, rsp_ready=1 -> req_ready[0] same cycle; 3 cycles later rsp_valid=1, rsp_id=0, rsp_data=5000; idle=1 after; cnt_issue=1.
- Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1...; rsp_id follows the same order; one product per cycle. Operands a=63, b=262143 -> product 16515009 (no overflow).
- Backpressure: 3 ops in flight, rsp_ready=0 for 5 cycles -> mul_ce=0, req_ready=0, rsp_* stable; cnt_stall=5; all 3 products then delivered in order.
- Bubbles: requests on alternate cycles -> responses on alternate cycles; no spurious rsp_valid.
- Mid-op reset: assert reset with 2 ops in flight -> rsp_valid=0, idle=1, counters 0 immediately; after release, a new op returns the correct product only (no stale products).
- Skip idle requesters: only req1 and req3 valid, rr_ptr=0 -> grants alternate 1,3,1,3.

Source files
------------

// File: rtl/conv_sysarr_mul_share_arb.sv
// Round-robin share of one external pipelined multiplier between N_REQ
// systolic-array requesters. A tag shift register runs in lockstep with the
// multiplier pipeline so each product returns with its requester ID.
// Response backpressure freezes the entire pipeline through mul_ce.
module conv_sysarr_mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [6*N_REQ-1:0]    req_a,
    input  logic [18*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  mul_ce,
    output logic [5:0]            mul_din0,
    output logic [17:0]           mul_din1,
    input  logic [23:0]           mul_dout,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [23:0]           rsp_data,
    input  logic                  rsp_ready,
    output logic                  idle,
    output logic [CNT_W-1:0]      cnt_issue,
    output logic [CNT_W-1:0]      cnt_stall
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_found;
    logic            accept;
    logic            stall;
    logic            tag_v  [MUL_LAT];
    logic [ID_W-1:0] tag_id [MUL_LAT];

    // Stall whenever a product is waiting and downstream refuses it; mul_ce
    // is also held low during reset so the multiplier never advances then.
    always_comb begin
        stall  = rsp_valid & ~rsp_ready;
        mul_ce = ~stall & reset;
    end

    // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    // Grant decode and operand mux; ready is withheld while stalled.
    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = mul_ce;
            mul_din0           = req_a[int'(gnt_idx)*6 +: 6];
            mul_din1           = req_b[int'(gnt_idx)*18 +: 18];
        end
        accept = gnt_found & mul_ce;
    end

    // Pointer moves past the winner only when a transfer actually happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (int'(gnt_idx) == N_REQ - 1)
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_idx + 1'b1;
        end
    end

    // Tag pipeline mirrors multiplier stages; advances only with mul_ce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
        end else if (mul_ce) begin
            tag_v[0]  <= accept;
            tag_id[0] <= gnt_idx;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // Response comes straight from the last tag stage and the multiplier.
    always_comb begin
        rsp_valid = tag_v[MUL_LAT-1];
        rsp_id    = tag_id[MUL_LAT-1];
        rsp_data  = mul_dout;
        idle      = 1'b1;
        for (int s = 0; s < MUL_LAT; s++)
            if (tag_v[s]) idle = 1'b0;
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_issue <= '0;
            cnt_stall <= '0;
        end else begin
            if (accept)  cnt_issue <= cnt_issue + 1'b1;
            if (!mul_ce) cnt_stall <= cnt_stall + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_sysarr_mul_share_arb.sv
module tb_conv_sysarr_mul_share_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [23:0]  req_a;
    logic [71:0]  req_b;
    logic [3:0]   req_ready;
    logic         mul_ce;
    logic [5:0]   mul_din0;
    logic [17:0]  mul_din1;
    logic [23:0]  mul_dout;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [23:0]  rsp_data;
    logic         rsp_ready;
    logic         idle;
    logic [31:0]  cnt_issue;
    logic [31:0]  cnt_stall;

    int checks = 0;
    int errors = 0;

    conv_sysarr_mul_share_arb dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .idle(idle), .cnt_issue(cnt_issue), .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    // External 3-stage ce-gated multiplier, contents not reset.
    logic [23:0] m0, m1, m2;
    always @(posedge clk) begin
        if (mul_ce) begin
            m0 <= 24'(mul_din0) * 24'(mul_din1);
            m1 <= m0;
            m2 <= m1;
        end
    end
    assign mul_dout = m2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [5:0] a, input logic [17:0] b);
        req_a[i*6 +: 6]   = a;
        req_b[i*18 +: 18] = b;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'hF;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (mul_ce !== 1'b0) begin errors++; $display("FAIL reset_mul_ce got %b want 0", mul_ce); end
        checks++; if (cnt_issue !== 32'd0 || cnt_stall !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_issue, cnt_stall); end
        req_valid = '0;
    endtask

    task automatic test_single_op();
        do_reset();
        tick();
        set_op(0, 6'd5, 18'd1000);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            if (k < 3) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp cyc %0d got %b want 0", k, rsp_valid); end
            end else if (k == 3) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'd5000) begin
                    errors++; $display("FAIL single_rsp got v=%b id=%0d d=%0d want v=1 id=0 d=5000", rsp_valid, rsp_id, rsp_data); end
            end else begin
                checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL single_after got v=%b idle=%b want 0/1", rsp_valid, idle); end
                checks++; if (cnt_issue !== 32'd1) begin errors++; $display("FAIL single_cnt_issue got %0d want 1", cnt_issue); end
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) set_op(i, 6'd63, 18'd262143);
        req_valid = 4'hF;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick();
            if (k == 9) req_valid = '0;
            @(negedge clk);
            if (k < 9) begin
                checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL fair_grant cyc %0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
            end
            if (k >= 3) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 3) % 4) || rsp_data !== 24'd16515009) begin
                    errors++; $display("FAIL fair_rsp cyc %0d got v=%b id=%0d d=%0d want v=1 id=%0d d=16515009", k, rsp_valid, rsp_id, rsp_data, (k - 3) % 4); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_d [4];
        exp_d[0] = 24'd6; exp_d[1] = 24'd20; exp_d[2] = 24'd77; exp_d[3] = 24'd900;
        do_reset();
        tick();
        set_op(0, 6'd2, 18'd3);
        set_op(1, 6'd4, 18'd5);
        set_op(2, 6'd7, 18'd11);
        set_op(3, 6'd9, 18'd100);
        req_valid = 4'b0111;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            if (k == 3) begin req_valid = 4'b1000; rsp_ready = 1'b0; end
            if (k == 8) rsp_ready = 1'b1;
            if (k == 9) req_valid = '0;
            @(negedge clk);
            if (k < 3) begin
                checks++; if (req_ready !== (4'b0001 << k)) begin errors++; $display("FAIL bp_grant cyc %0d got %b want %b", k, req_ready, 4'b0001 << k); end
            end else if (k < 8) begin
                checks++; if (mul_ce !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL bp_stall cyc %0d got ce=%b rdy=%b want 0/0000", k, mul_ce, req_ready); end
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'd6) begin
                    errors++; $display("FAIL bp_hold cyc %0d got v=%b id=%0d d=%0d want 1/0/6", k, rsp_valid, rsp_id, rsp_data); end
            end else if (k < 12) begin
                if (k == 8) begin
                    checks++; if (cnt_stall !== 32'd5) begin errors++; $display("FAIL bp_cnt_stall got %0d want 5", cnt_stall); end
                    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume_grant got %b want 1000", req_ready); end
                end
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k - 8) || rsp_data !== exp_d[k-8]) begin
                    errors++; $display("FAIL bp_drain cyc %0d got v=%b id=%0d d=%0d want 1/%0d/%0d", k, rsp_valid, rsp_id, rsp_data, k - 8, exp_d[k-8]); end
            end else begin
                checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1 || cnt_issue !== 32'd4) begin
                    errors++; $display("FAIL bp_end got v=%b idle=%b issue=%0d want 0/1/4", rsp_valid, idle, cnt_issue); end
            end
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            req_valid = (k % 2 == 0 && k < 6) ? 4'b0001 : 4'b0000;
            set_op(0, 6'(k / 2 + 1), 18'd10);
            @(negedge clk);
            checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL bub_ready cyc %0d got %b want %b", k, req_ready, req_valid); end
            if (k >= 3 && k <= 7 && k % 2 == 1) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'(((k - 3) / 2 + 1) * 10)) begin
                    errors++; $display("FAIL bub_rsp cyc %0d got v=%b id=%0d d=%0d want 1/0/%0d", k, rsp_valid, rsp_id, rsp_data, ((k - 3) / 2 + 1) * 10); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bub_spurious cyc %0d got %b want 0", k, rsp_valid); end
            end
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        tick();
        set_op(0, 6'd10, 18'd10);
        set_op(1, 6'd11, 18'd11);
        req_valid = 4'b0011;
        tick();
        tick();
        req_valid = '0;
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1 || req_ready !== 4'b0) begin
            errors++; $display("FAIL mid_reset got v=%b idle=%b rdy=%b want 0/1/0000", rsp_valid, idle, req_ready); end
        checks++; if (cnt_issue !== 32'd0 || cnt_stall !== 32'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d/%0d want 0/0", cnt_issue, cnt_stall); end
        tick();
        tick();
        reset = 1'b1;
        set_op(0, 6'd6, 18'd7);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            req_valid = (k == 1) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (k == 4) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'd42) begin
                    errors++; $display("FAIL mid_new_rsp got v=%b id=%0d d=%0d want 1/0/42", rsp_valid, rsp_id, rsp_data); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cyc %0d got %b want 0", k, rsp_valid); end
            end
        end
    endtask

    task automatic test_skip_idle();
        do_reset();
        tick();
        set_op(1, 6'd1, 18'd1);
        set_op(3, 6'd3, 18'd3);
        req_valid = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            checks++; if (req_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                errors++; $display("FAIL skip_grant cyc %0d got %b want %b", k, req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000); end
            if (k >= 3) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== ((k % 2 == 1) ? 2'd1 : 2'd3) || rsp_data !== ((k % 2 == 1) ? 24'd1 : 24'd9)) begin
                    errors++; $display("FAIL skip_rsp cyc %0d got v=%b id=%0d d=%0d", k, rsp_valid, rsp_id, rsp_data); end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_bubbles();
        test_midop_reset();
        test_skip_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
